// File: rtl/food_place_ctrl.sv
// Food placement sequencer: steps the X/Y position generators, range-checks each
// candidate, asks the body memory whether the cell is free, and retries up to MAX_TRIES.
module food_place_ctrl #(
  parameter int X_MAX     = 79,
  parameter int Y_MAX     = 59,
  parameter int MAX_TRIES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       place_req,
  input  logic [6:0] rnd_x,
  input  logic [6:0] rnd_y,
  output logic       rnd_ce,
  output logic       occ_req,
  output logic [6:0] occ_x,
  output logic [6:0] occ_y,
  input  logic       occ_ack,
  input  logic       occ_hit,
  output logic [6:0] food_x,
  output logic [6:0] food_y,
  output logic       food_valid,
  output logic       busy,
  output logic       fail
);

  localparam logic [6:0] X_LIM = 7'(X_MAX);
  localparam logic [6:0] Y_LIM = 7'(Y_MAX);

  typedef enum logic [1:0] {IDLE, ADVANCE, SAMPLE, QUERY} state_t;

  state_t     state;
  logic [7:0] tries;
  logic [6:0] cand_x;
  logic [6:0] cand_y;

  logic [8:0] tries_inc;
  logic [7:0] tries_sat;
  logic       last_try;
  logic       range_bad;
  logic       reject;

  always_comb begin
    tries_inc = {1'b0, tries} + 9'd1;
    tries_sat = (tries == 8'hFF) ? tries : tries_inc[7:0];
    last_try  = (tries_inc == 9'(MAX_TRIES));
    range_bad = (rnd_x > X_LIM) || (rnd_y > Y_LIM);
    reject    = ((state == SAMPLE) && range_bad) ||
                ((state == QUERY) && occ_ack && occ_hit);
  end

  // A rejected candidate, from either the range check or an occupied cell, shares
  // one retry path; it overrides whatever the per-state branch scheduled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      tries      <= 8'd0;
      cand_x     <= 7'd0;
      cand_y     <= 7'd0;
      rnd_ce     <= 1'b0;
      occ_req    <= 1'b0;
      occ_x      <= 7'd0;
      occ_y      <= 7'd0;
      food_x     <= 7'd0;
      food_y     <= 7'd0;
      food_valid <= 1'b0;
      busy       <= 1'b0;
      fail       <= 1'b0;
    end else begin
      rnd_ce <= 1'b0;
      fail   <= 1'b0;
      case (state)
        IDLE: begin
          if (place_req) begin
            state      <= ADVANCE;
            rnd_ce     <= 1'b1;
            food_valid <= 1'b0;
            busy       <= 1'b1;
            tries      <= 8'd0;
          end
        end
        ADVANCE: begin
          state <= SAMPLE;
        end
        SAMPLE: begin
          cand_x <= rnd_x;
          cand_y <= rnd_y;
          if (!range_bad) begin
            state   <= QUERY;
            occ_req <= 1'b1;
            occ_x   <= rnd_x;
            occ_y   <= rnd_y;
          end
        end
        QUERY: begin
          if (occ_ack) begin
            occ_req <= 1'b0;
            if (!occ_hit) begin
              food_x     <= cand_x;
              food_y     <= cand_y;
              food_valid <= 1'b1;
              busy       <= 1'b0;
              state      <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase

      if (reject) begin
        tries <= tries_sat;
        if (last_try) begin
          fail  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end else begin
          rnd_ce <= 1'b1;
          state  <= ADVANCE;
        end
      end
    end
  end

endmodule

// File: tb/tb_food_place_ctrl.sv
// Bench for food_place_ctrl: models the position generators and the body memory,
// runs a vector table, hand-written corner sequences and randomized placements.
module tb_food_place_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       place_req = 1'b0;
  logic [6:0] rnd_x;
  logic [6:0] rnd_y;
  logic       rnd_ce;
  logic       occ_req;
  logic [6:0] occ_x;
  logic [6:0] occ_y;
  logic       occ_ack = 1'b0;
  logic       occ_hit = 1'b0;
  logic [6:0] food_x;
  logic [6:0] food_y;
  logic       food_valid;
  logic       busy;
  logic       fail;

  food_place_ctrl dut (
    .clk(clk), .rst_n(rst_n), .place_req(place_req),
    .rnd_x(rnd_x), .rnd_y(rnd_y), .rnd_ce(rnd_ce),
    .occ_req(occ_req), .occ_x(occ_x), .occ_y(occ_y),
    .occ_ack(occ_ack), .occ_hit(occ_hit),
    .food_x(food_x), .food_y(food_y), .food_valid(food_valid),
    .busy(busy), .fail(fail)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  // Generator model: gx/gy[k] is shown after k enable pulses since gen_base.
  int gx[32];
  int gy[32];
  int gen_idx = 0;
  int gen_base = 0;
  always @(posedge clk) if (rnd_ce === 1'b1) gen_idx <= gen_idx + 1;
  assign rnd_x = 7'(gx[(gen_idx - gen_base) % 32]);
  assign rnd_y = 7'(gy[(gen_idx - gen_base) % 32]);

  // Body memory model with programmable answer delay and occupancy map.
  bit         occ_map[128][128];
  int         dly = 0;
  bit         hit_all = 1'b0;
  bit         stray = 1'b0;
  int         wait_cnt = 0;
  bit         in_q = 1'b0;
  logic [6:0] q_x, q_y;

  task automatic check_output(string name, int act, int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (occ_req === 1'b1) begin
      if (!in_q) begin
        q_x = occ_x;
        q_y = occ_y;
        in_q = 1'b1;
      end else begin
        check_output("occ_xy_stable", {occ_x, occ_y}, {q_x, q_y});
      end
      if (wait_cnt >= dly) begin
        occ_ack = 1'b1;
        occ_hit = hit_all | occ_map[occ_x][occ_y];
      end else begin
        occ_ack = 1'b0;
        wait_cnt++;
      end
    end else begin
      occ_ack = stray;
      occ_hit = 1'b0;
      wait_cnt = 0;
      in_q = 1'b0;
    end
  end

  typedef struct packed {
    logic [1:0]      n;
    logic [2:0][6:0] cx;
    logic [2:0][6:0] cy;
    logic [2:0]      hit;
    logic [3:0]      dly;
    logic [6:0]      ex;
    logic [6:0]      ey;
    logic            efail;
    logic [5:0]      ece;
    logic [7:0]      eedge;
  } vec_t;

  function automatic vec_t mk(input int n, input int x0, input int y0, input int h0,
                              input int x1, input int y1, input int h1,
                              input int x2, input int y2, input int h2,
                              input int d, input int ex, input int ey, input int ef,
                              input int ece, input int eedge);
    vec_t v;
    v.n = 2'(n);
    v.cx[0] = 7'(x0); v.cy[0] = 7'(y0); v.hit[0] = 1'(h0);
    v.cx[1] = 7'(x1); v.cy[1] = 7'(y1); v.hit[1] = 1'(h1);
    v.cx[2] = 7'(x2); v.cy[2] = 7'(y2); v.hit[2] = 1'(h2);
    v.dly = 4'(d); v.ex = 7'(ex); v.ey = 7'(ey); v.efail = 1'(ef);
    v.ece = 6'(ece); v.eedge = 8'(eedge);
    return v;
  endfunction

  task automatic clear_map();
    for (int i = 0; i < 128; i++)
      for (int j = 0; j < 128; j++)
        occ_map[i][j] = 1'b0;
  endtask

  task automatic load_vec(input vec_t v);
    clear_map();
    for (int i = 0; i < 32; i++) begin
      gx[i] = 127;
      gy[i] = 127;
    end
    gx[0] = 0;
    gy[0] = 0;
    for (int i = 0; i < int'(v.n); i++) begin
      gx[i+1] = int'(v.cx[i]);
      gy[i+1] = int'(v.cy[i]);
      occ_map[v.cx[i]][v.cy[i]] = v.hit[i];
    end
    dly = int'(v.dly);
  endtask

  // One placement: pulse place_req, count edges until food_valid or fail, then compare.
  task automatic apply_stimulus(input int poke, input int exp_x, input int exp_y,
                                input int exp_fail, input int exp_ce, input int exp_edge);
    int edges;
    bit done;
    @(negedge clk);
    gen_base = gen_idx;
    place_req = 1'b1;
    @(posedge clk);
    edges = 1;
    @(negedge clk);
    place_req = 1'b0;
    check_output("busy_after_req", int'(busy), 1);
    check_output("valid_cleared", int'(food_valid), 0);
    done = 1'b0;
    while (!done && edges < 600) begin
      if (food_valid === 1'b1 || fail === 1'b1) done = 1'b1;
      else begin
        @(posedge clk);
        edges++;
        @(negedge clk);
        place_req = (edges == poke);
      end
    end
    place_req = 1'b0;
    check_output("done_edge", edges, exp_edge);
    check_output("food_x", int'(food_x), exp_x);
    check_output("food_y", int'(food_y), exp_y);
    check_output("food_valid", int'(food_valid), exp_fail ? 0 : 1);
    check_output("fail", int'(fail), exp_fail);
    check_output("busy_done", int'(busy), 0);
    check_output("rnd_ce_pulses", gen_idx - gen_base, exp_ce);
    @(negedge clk);
    check_output("fail_one_cycle", int'(fail), 0);
    check_output("no_extra_ce", gen_idx - gen_base, exp_ce);
  endtask

  vec_t vecs[6];
  int   last_fx = 0;
  int   last_fy = 0;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    for (int i = 0; i < 32; i++) begin
      gx[i] = 0;
      gy[i] = 0;
    end
    clear_map();

    vecs[0] = mk(1, 10, 20, 0,   0,  0, 0,   0,  0, 0, 0, 10, 20, 0, 1,  4);
    vecs[1] = mk(3, 100, 5, 0,   5, 60, 0,  30, 30, 0, 0, 30, 30, 0, 3,  8);
    vecs[2] = mk(2, 7,  7,  1,   8,  9, 0,   0,  0, 0, 3,  8,  9, 0, 2, 13);
    vecs[3] = mk(1, 79, 59, 0,   0,  0, 0,   0,  0, 0, 1, 79, 59, 0, 1,  5);
    vecs[4] = mk(3, 80, 59, 0,  79, 60, 0,   0,  0, 0, 0,  0,  0, 0, 3,  8);
    vecs[5] = mk(3, 127,127,0,   3,  3, 1,   4,  4, 0, 2,  4,  4, 0, 3, 13);

    #12;
    check_output("reset_busy", int'(busy), 0);
    check_output("reset_occ_req", int'(occ_req), 0);
    check_output("reset_rnd_ce", int'(rnd_ce), 0);
    check_output("reset_valid", int'(food_valid), 0);
    check_output("reset_fail", int'(fail), 0);
    check_output("reset_food", {food_x, food_y}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int k = 0; k < 6; k++) begin
      load_vec(vecs[k]);
      apply_stimulus(0, int'(vecs[k].ex), int'(vecs[k].ey), int'(vecs[k].efail),
                     int'(vecs[k].ece), int'(vecs[k].eedge));
      last_fx = int'(vecs[k].ex);
      last_fy = int'(vecs[k].ey);
    end

    // Exhaust: every in-range cell reads occupied, food stays at the old cell
    clear_map();
    for (int i = 0; i < 32; i++) begin
      gx[i] = i;
      gy[i] = i;
    end
    hit_all = 1'b1;
    dly = 0;
    apply_stimulus(0, last_fx, last_fy, 1, 16, 49);
    hit_all = 1'b0;

    // Ignore: request during QUERY, then stray acks while idle
    load_vec(mk(1, 12, 13, 0, 0, 0, 0, 0, 0, 0, 4, 12, 13, 0, 1, 8));
    apply_stimulus(4, 12, 13, 0, 1, 8);
    last_fx = 12;
    last_fy = 13;
    gen_base = gen_idx;
    stray = 1'b1;
    repeat (5) @(negedge clk);
    stray = 1'b0;
    check_output("stray_ack_busy", int'(busy), 0);
    check_output("stray_ack_ce", gen_idx - gen_base, 0);
    check_output("stray_ack_valid", int'(food_valid), 1);
    check_output("stray_ack_food", {food_x, food_y}, {7'd12, 7'd13});

    // Reset while a query is outstanding
    load_vec(mk(1, 20, 21, 0, 0, 0, 0, 0, 0, 0, 10, 0, 0, 0, 0, 0));
    @(negedge clk);
    gen_base = gen_idx;
    place_req = 1'b1;
    @(negedge clk);
    place_req = 1'b0;
    for (int i = 0; i < 10 && occ_req !== 1'b1; i++) @(negedge clk);
    check_output("query_reached", int'(occ_req), 1);
    #2 rst_n = 1'b0;
    #1;
    check_output("rst_occ_req", int'(occ_req), 0);
    check_output("rst_busy", int'(busy), 0);
    check_output("rst_valid", int'(food_valid), 0);
    check_output("rst_food", {food_x, food_y}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    last_fx = 0;
    last_fy = 0;
    load_vec(vecs[0]);
    apply_stimulus(0, 10, 20, 0, 1, 4);
    last_fx = 10;
    last_fy = 20;

    // Randomized placements against a rule-level model
    for (int it = 0; it < 25; it++) begin
      int rej, edges, ce, ef, ex, ey;
      bit fin;
      clear_map();
      dly = $urandom_range(0, 3);
      gx[0] = 0;
      gy[0] = 0;
      for (int i = 1; i < 32; i++) begin
        gx[i] = $urandom_range(0, 90);
        gy[i] = $urandom_range(0, 68);
        if (gx[i] <= 79 && gy[i] <= 59 && $urandom_range(0, 1) == 1)
          occ_map[gx[i]][gy[i]] = 1'b1;
      end
      rej = 0; edges = 1; ce = 0; ef = 0; ex = last_fx; ey = last_fy; fin = 1'b0;
      for (int i = 1; i < 32 && !fin; i++) begin
        ce++;
        if (gx[i] > 79 || gy[i] > 59) begin
          edges += 2;
          rej++;
        end else begin
          edges += 3 + dly;
          if (occ_map[gx[i]][gy[i]]) rej++;
          else begin
            ex = gx[i];
            ey = gy[i];
            fin = 1'b1;
          end
        end
        if (!fin && rej == 16) begin
          ef = 1;
          fin = 1'b1;
        end
      end
      apply_stimulus(0, ex, ey, ef, ce, edges);
      last_fx = ex;
      last_fy = ey;
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
